// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM encoding, game codes, ASCII constants and text helpers
// for the LCD text formatter.
package lcd_pkg;
    typedef enum logic [1:0] {S_IDLE, S_CONV_SCORE, S_CONV_BEST, S_PACK} state_t;
    localparam logic [1:0] GS_IDLE = 2'd0;
    localparam logic [1:0] GS_PLAY = 2'd1;
    localparam logic [1:0] GS_OVER = 2'd2;
    localparam int SCORE_MAX = 9999;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [47:0] LBL_SCORE = "SCORE ";
    localparam logic [47:0] LBL_BEST = "BEST  ";
    localparam logic [47:0] LBL_PAD = "      ";
    localparam logic [47:0] STR_IDLE = "  IDLE";
    localparam logic [47:0] STR_PLAY = "  PLAY";
    localparam logic [47:0] STR_OVER = "  OVER";
    localparam logic [47:0] STR_RSVD = "  ----";
    localparam logic [127:0] ROW1_RST = "SCORE 0000      ";
    localparam logic [127:0] ROW2_RST = "BEST  0000  IDLE";

    // One shift-add-3 step: correct each nibble, then shift in the next binary bit.
    function automatic logic [15:0] bcd_step(input logic [15:0] b, input logic bit_in);
        logic [15:0] a;
        for (int i = 0; i < 4; i++)
            a[4*i+:4] = (b[4*i+:4] >= 4'd5) ? b[4*i+:4] + 4'd3 : b[4*i+:4];
        return {a[14:0], bit_in};
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return (d > 4'd9) ? ASCII_SPACE : ASCII_ZERO + {4'd0, d};
    endfunction

    function automatic logic [31:0] bcd_ascii(input logic [15:0] b);
        return {to_ascii(b[15:12]), to_ascii(b[11:8]), to_ascii(b[7:4]), to_ascii(b[3:0])};
    endfunction

    function automatic logic [47:0] status_str(input logic [1:0] gs);
        return (gs == GS_IDLE) ? STR_IDLE :
               (gs == GS_PLAY) ? STR_PLAY :
               (gs == GS_OVER) ? STR_OVER : STR_RSVD;
    endfunction
endpackage

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: shift-add-3 binary to 4-digit BCD, one bit per cycle.
// The start edge already consumes the MSB, so a conversion spans CONV_BITS edges.
module bin2bcd_serial #(
    parameter int CONV_BITS = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CONV_BITS-1:0] din,
    output logic                 done,
    output logic [15:0]          bcd
);
    import lcd_pkg::*;
    localparam int CW = $clog2(CONV_BITS + 1);
    logic [CONV_BITS-1:0] sr;
    logic [CW-1:0]        cnt;
    logic                 running;

    assign done = running && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            cnt     <= '0;
            running <= 1'b0;
            bcd     <= '0;
        end else if (start) begin
            bcd     <= bcd_step(16'h0, din[CONV_BITS-1]);
            sr      <= {din[CONV_BITS-2:0], 1'b0};
            cnt     <= CW'(CONV_BITS - 1);
            running <= 1'b1;
        end else if (running) begin
            if (cnt != '0) begin
                bcd <= bcd_step(bcd, sr[CONV_BITS-1]);
                sr  <= {sr[CONV_BITS-2:0], 1'b0};
                cnt <= cnt - 1'b1;
            end else begin
                running <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/lcd_text_fmt.sv
// lcd_text_fmt: builds two 16-char LCD rows showing score, best score and game status,
// converting both numbers through one shared serial BCD converter.
module lcd_text_fmt #(
    parameter int SCORE_MAX = lcd_pkg::SCORE_MAX,
    parameter int CONV_BITS = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CONV_BITS-1:0] score,
    input  logic [1:0]           game_state,
    input  logic                 update,
    output logic [127:0]         row_1,
    output logic [127:0]         row_2,
    output logic                 busy,
    output logic                 frame_valid,
    output logic [CONV_BITS-1:0] best
);
    import lcd_pkg::*;
    state_t               state;
    logic [1:0]           gs_q;
    logic [15:0]          score_bcd;
    logic [15:0]          bcd;
    logic [CONV_BITS-1:0] clamped;
    logic [CONV_BITS-1:0] din;
    logic                 start;
    logic                 done;

    assign busy = (state != S_IDLE);

    // Best is already updated when the second conversion starts, so it feeds din directly.
    always_comb begin
        clamped = (score > CONV_BITS'(SCORE_MAX)) ? CONV_BITS'(SCORE_MAX) : score;
        start   = ((state == S_IDLE) && update) || ((state == S_CONV_SCORE) && done);
        din     = (state == S_IDLE) ? clamped : best;
    end

    bin2bcd_serial #(.CONV_BITS(CONV_BITS)) u_conv (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .din  (din),
        .done (done),
        .bcd  (bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            gs_q        <= GS_IDLE;
            score_bcd   <= '0;
            best        <= '0;
            frame_valid <= 1'b0;
            row_1       <= ROW1_RST;
            row_2       <= ROW2_RST;
        end else begin
            frame_valid <= 1'b0;
            case (state)
                S_IDLE: if (update) begin
                    gs_q  <= game_state;
                    best  <= (clamped > best) ? clamped : best;
                    state <= S_CONV_SCORE;
                end
                S_CONV_SCORE: if (done) begin
                    score_bcd <= bcd;
                    state     <= S_CONV_BEST;
                end
                S_CONV_BEST: if (done) state <= S_PACK;
                S_PACK: begin
                    row_1       <= {LBL_SCORE, bcd_ascii(score_bcd), LBL_PAD};
                    row_2       <= {LBL_BEST, bcd_ascii(bcd), status_str(gs_q)};
                    frame_valid <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
